// File: rtl/tour_pkg.sv
// Shared constants for tour playback: move one-hots, command opcodes/headings, FSM states.
// No logic; imported by the tour_cmd block and its decoder.
package tour_pkg;

    localparam logic [7:0] MV_B0 = 8'h01;
    localparam logic [7:0] MV_B1 = 8'h02;
    localparam logic [7:0] MV_B2 = 8'h04;
    localparam logic [7:0] MV_B3 = 8'h08;
    localparam logic [7:0] MV_B4 = 8'h10;
    localparam logic [7:0] MV_B5 = 8'h20;
    localparam logic [7:0] MV_B6 = 8'h40;
    localparam logic [7:0] MV_B7 = 8'h80;

    localparam logic [3:0] OP_MOVE    = 4'h4;
    localparam logic [3:0] OP_FANFARE = 4'h5;

    localparam logic [7:0] HD_N = 8'h00;
    localparam logic [7:0] HD_W = 8'h3F;
    localparam logic [7:0] HD_S = 8'h7F;
    localparam logic [7:0] HD_E = 8'hBF;

    localparam logic [4:0] LAST_IDX  = 5'd23;
    localparam logic [7:0] RESP_IDLE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VERT   = 3'd1,
        WAIT_V = 3'd2,
        HORZ   = 3'd3,
        WAIT_H = 3'd4
    } state_t;

    function automatic logic is_onehot(input logic [7:0] m);
        return (m != 8'h00) && ((m & (m - 8'h01)) == 8'h00);
    endfunction

endpackage

// File: rtl/tour_cmd_if.sv
// Bundle of the tour solver, UART and motion-controller channels seen by tour_cmd.
// master = environment side, slave = tour_cmd side.
interface tour_cmd_if;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        err;

    modport master (
        output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp, err
    );

    modport slave (
        input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp, err
    );
endinterface

// File: rtl/tour_move_decode.sv
// Maps a knight move one-hot to vertical/horizontal heading and square count.
// Purely combinational; lowest set bit wins, move == 0 gives north/0 on both legs.
module tour_move_decode
    import tour_pkg::*;
(
    input  logic [7:0] move,
    output logic [7:0] v_head,
    output logic [3:0] v_sq,
    output logic [7:0] h_head,
    output logic [3:0] h_sq
);

    always_comb begin
        v_head = HD_N;
        v_sq   = 4'd0;
        h_head = HD_N;
        h_sq   = 4'd0;
        priority casez (move)
            8'b???????1: begin v_head = HD_N; v_sq = 4'd2; h_head = HD_W; h_sq = 4'd1; end
            8'b??????10: begin v_head = HD_N; v_sq = 4'd2; h_head = HD_E; h_sq = 4'd1; end
            8'b?????100: begin v_head = HD_N; v_sq = 4'd1; h_head = HD_W; h_sq = 4'd2; end
            8'b????1000: begin v_head = HD_S; v_sq = 4'd1; h_head = HD_W; h_sq = 4'd2; end
            8'b???10000: begin v_head = HD_S; v_sq = 4'd2; h_head = HD_W; h_sq = 4'd1; end
            8'b??100000: begin v_head = HD_S; v_sq = 4'd2; h_head = HD_E; h_sq = 4'd1; end
            8'b?1000000: begin v_head = HD_S; v_sq = 4'd1; h_head = HD_E; h_sq = 4'd2; end
            8'b10000000: begin v_head = HD_N; v_sq = 4'd1; h_head = HD_E; h_sq = 4'd2; end
            default:     ;
        endcase
    end

endmodule

// File: rtl/tour_cmd.sv
// Plays a 24-move knight tour as vertical+horizontal motion commands; passes UART commands through when idle.
// Latency: one cycle from start_tour/clr_cmd_rdy/send_resp to the next state; cmd holds while cmd_rdy is high.
// Optional TOUR_CMD_CHK_EN: non-one-hot move in VERT sets sticky err and aborts the tour.
module tour_cmd
    import tour_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    tour_cmd_if.slave    bus
);

    state_t      state, nxt;
    logic [4:0]  indx;
    logic [7:0]  v_head, h_head;
    logic [3:0]  v_sq, h_sq;
    logic        bad_move;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_uart;
    logic [7:0]  resp;
    logic [3:0]  h_op;

    tour_move_decode u_dec (
        .move   (bus.move),
        .v_head (v_head),
        .v_sq   (v_sq),
        .h_head (h_head),
        .h_sq   (h_sq)
    );

`ifdef TOUR_CMD_CHK_EN
    logic err;
    assign bad_move = !is_onehot(bus.move);

    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (state == IDLE && bus.start_tour)
            err <= 1'b0;
        else if (state == VERT && bad_move)
            err <= 1'b1;
    end
    assign bus.err = err;
`else
    assign bad_move = 1'b0;
    assign bus.err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            indx  <= 5'd0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.start_tour)
                indx <= 5'd0;
            else if (state == WAIT_H && bus.send_resp && indx != LAST_IDX)
                indx <= indx + 5'd1;
        end
    end

    assign h_op = (indx == LAST_IDX) ? OP_FANFARE : OP_MOVE;

    // Wait states keep presenting the last command so cmd never glitches around cmd_rdy edges.
    always_comb begin
        nxt      = state;
        cmd      = 16'h0000;
        cmd_rdy  = 1'b0;
        clr_uart = 1'b0;
        resp     = RESP_BUSY;
        case (state)
            IDLE: begin
                cmd      = bus.cmd_UART;
                cmd_rdy  = bus.cmd_rdy_UART;
                clr_uart = bus.clr_cmd_rdy;
                resp     = RESP_IDLE;
                if (bus.start_tour)
                    nxt = VERT;
            end
            VERT: begin
                cmd = {OP_MOVE, v_head, v_sq};
                if (bad_move) begin
                    nxt = IDLE;
                end else begin
                    cmd_rdy = 1'b1;
                    if (bus.clr_cmd_rdy)
                        nxt = WAIT_V;
                end
            end
            WAIT_V: begin
                cmd = {OP_MOVE, v_head, v_sq};
                if (bus.send_resp)
                    nxt = HORZ;
            end
            HORZ: begin
                cmd     = {h_op, h_head, h_sq};
                cmd_rdy = 1'b1;
                if (bus.clr_cmd_rdy)
                    nxt = WAIT_H;
            end
            WAIT_H: begin
                cmd = {h_op, h_head, h_sq};
                if (bus.send_resp)
                    nxt = (indx == LAST_IDX) ? IDLE : VERT;
            end
            default: nxt = IDLE;
        endcase
    end

    assign bus.indx             = indx;
    assign bus.cmd              = cmd;
    assign bus.cmd_rdy          = cmd_rdy;
    assign bus.clr_cmd_rdy_UART = clr_uart;
    assign bus.resp             = resp;

endmodule

// File: tb/tb_tour_cmd.sv
// Randomized bench for tour_cmd against a (dx,dy) knight-move reference model.
module tb_tour_cmd;
    import tour_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tour_cmd_if bus();

    tour_cmd dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_cmds   = 0;
    int dx_tab [8] = '{-1,  1, -2, -2, -1,  1,  2,  2};
    int dy_tab [8] = '{ 2,  2,  1, -1, -2, -2, -1,  1};
    logic [7:0]  mv [24];
    logic [15:0] last_cmd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_cmd(input logic [7:0] m, input bit horiz, input int k);
        int dx = 0;
        int dy = 0;
        int d;
        logic [3:0] op;
        logic [7:0] hd;
        for (int b = 7; b >= 0; b--)
            if (m[b]) begin dx = dx_tab[b]; dy = dy_tab[b]; end
        op = (horiz && k == 23) ? 4'h5 : 4'h4;
        d  = horiz ? dx : dy;
        if (horiz) hd = (d > 0) ? 8'hBF : (d < 0) ? 8'h3F : 8'h00;
        else       hd = (d < 0) ? 8'h7F : 8'h00;
        return {op, hd, 4'(d < 0 ? -d : d)};
    endfunction

    function automatic logic [7:0] rand_onehot();
        logic [7:0] one = 8'h01;
        return one << $urandom_range(7, 0);
    endfunction

    // Enters at a negedge in VERT/HORZ; leaves at a negedge in the following wait state.
    task automatic leg(input string tag, input logic [15:0] exp, input int k);
        chk({tag, " cmd_rdy"}, {31'd0, bus.cmd_rdy}, 32'd1);
        chk({tag, " cmd"}, {16'd0, bus.cmd}, {16'd0, exp});
        chk({tag, " indx"}, {27'd0, bus.indx}, k);
        chk({tag, " resp"}, {24'd0, bus.resp}, 32'hA5 ^ 32'hFF);
        if (bus.cmd_rdy) n_cmds++;
        last_cmd = bus.cmd;
        repeat ($urandom_range(2, 0)) begin
            bus.send_resp    = 1'($urandom);
            bus.start_tour   = 1'($urandom);
            bus.cmd_UART     = 16'($urandom);
            bus.cmd_rdy_UART = 1'($urandom);
            @(negedge clk);
            bus.send_resp  = 1'b0;
            bus.start_tour = 1'b0;
            chk({tag, " hold rdy"}, {31'd0, bus.cmd_rdy}, 32'd1);
            chk({tag, " hold cmd"}, {16'd0, bus.cmd}, {16'd0, exp});
        end
        bus.clr_cmd_rdy = 1'b1;
        #1 chk({tag, " clr_uart busy"}, {31'd0, bus.clr_cmd_rdy_UART}, 32'd0);
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        chk({tag, " wait rdy"}, {31'd0, bus.cmd_rdy}, 32'd0);
        repeat ($urandom_range(2, 0)) begin
            bus.clr_cmd_rdy = 1'($urandom);
            @(negedge clk);
            bus.clr_cmd_rdy = 1'b0;
            chk({tag, " wait hold rdy"}, {31'd0, bus.cmd_rdy}, 32'd0);
            chk({tag, " wait indx"}, {27'd0, bus.indx}, k);
        end
    endtask

    // Plays mv[]; with abort_at >= 0 returns while waiting on the horizontal leg of that index.
    task automatic tour(input int abort_at);
        bus.move       = mv[0];
        bus.start_tour = 1'b1;
        @(negedge clk);
        bus.start_tour = 1'b0;
        for (int k = 0; k < 24; k++) begin
            leg("vert", model_cmd(mv[k], 1'b0, k), k);
            bus.send_resp = 1'b1;
            @(negedge clk);
            bus.send_resp = 1'b0;
            leg("horz", model_cmd(mv[k], 1'b1, k), k);
            if (k == abort_at) return;
            if (k < 23) bus.move = mv[k + 1];
            bus.send_resp = 1'b1;
            @(negedge clk);
            bus.send_resp = 1'b0;
        end
        chk("fanfare opcode", {28'd0, last_cmd[15:12]}, 32'h5);
        chk("tour end resp", {24'd0, bus.resp}, 32'hA5);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.start_tour = 1'b0; bus.move = 8'h00; bus.cmd_UART = 16'h0000;
        bus.cmd_rdy_UART = 1'b0; bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
        @(negedge clk);
        chk("reset indx", {27'd0, bus.indx}, 32'd0);
        chk("reset err", {31'd0, bus.err}, 32'd0);
        chk("reset resp", {24'd0, bus.resp}, 32'hA5);
        rst = 1'b0;

        bus.cmd_UART = 16'h4123; bus.cmd_rdy_UART = 1'b1; bus.clr_cmd_rdy = 1'b1;
        #1;
        chk("idle cmd pass", {16'd0, bus.cmd}, 32'h4123);
        chk("idle rdy pass", {31'd0, bus.cmd_rdy}, 32'd1);
        chk("idle clr pass", {31'd0, bus.clr_cmd_rdy_UART}, 32'd1);
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0; bus.cmd_rdy_UART = 1'b0;

        // Fixed moves at the head of the tour, then random ones.
        foreach (mv[i]) mv[i] = rand_onehot();
        mv[0] = 8'h01;
        mv[1] = 8'h40;
`ifndef TOUR_CMD_CHK_EN
        mv[2] = 8'h00;
        mv[3] = 8'h03;
        mv[4] = 8'($urandom);
`endif
        chk("model 01 vert", {16'd0, model_cmd(8'h01, 1'b0, 0)}, 32'h4002);
        n_cmds = 0;
        tour(-1);
        chk("cmd count", n_cmds, 32'd48);
        chk("post tour err", {31'd0, bus.err}, 32'd0);
        bus.cmd_rdy_UART = 1'b1;
        #1 chk("post tour pass rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        @(negedge clk);
        bus.cmd_rdy_UART = 1'b0;

        // Abort mid-tour with reset.
        foreach (mv[i]) mv[i] = rand_onehot();
        tour(10);
        chk("pre-reset indx", {27'd0, bus.indx}, 32'd10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid reset indx", {27'd0, bus.indx}, 32'd0);
        chk("mid reset resp", {24'd0, bus.resp}, 32'hA5);
        chk("mid reset rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        chk("mid reset err", {31'd0, bus.err}, 32'd0);
        bus.cmd_rdy_UART = 1'b1; bus.cmd_UART = 16'h1234;
        #1;
        chk("mid reset rdy follow", {31'd0, bus.cmd_rdy}, 32'd1);
        chk("mid reset cmd follow", {16'd0, bus.cmd}, 32'h1234);
        bus.cmd_rdy_UART = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.send_resp   = 1'($urandom);
            bus.clr_cmd_rdy = 1'($urandom);
            @(negedge clk);
            bus.send_resp = 1'b0; bus.clr_cmd_rdy = 1'b0;
            chk("abandoned rdy", {31'd0, bus.cmd_rdy}, 32'd0);
            chk("abandoned resp", {24'd0, bus.resp}, 32'hA5);
        end

`ifdef TOUR_CMD_CHK_EN
        foreach (mv[i]) mv[i] = rand_onehot();
        mv[5] = 8'h03;
        tour(4);
        bus.move = mv[5];
        bus.send_resp = 1'b1;
        @(negedge clk);
        bus.send_resp = 1'b0;
        chk("bad move rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        chk("bad move indx", {27'd0, bus.indx}, 32'd5);
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        chk("bad move idle resp", {24'd0, bus.resp}, 32'hA5);
        chk("bad move err", {31'd0, bus.err}, 32'd1);
        chk("bad move idle rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("err sticky", {31'd0, bus.err}, 32'd1);
        end
        bus.move = 8'h01;
        bus.start_tour = 1'b1;
        @(negedge clk);
        bus.start_tour = 1'b0;
        chk("err cleared", {31'd0, bus.err}, 32'd0);
        chk("restart indx", {27'd0, bus.indx}, 32'd0);
        chk("restart rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`else
        bus.move = 8'h03;
        #1 chk("err tied low", {31'd0, bus.err}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port start_tour, input, 1: one-cycle pulse that starts a tour playback. Driven by the tour solver's done.
REQ-004 SHALL have port move, input, 8: one-hot move returned by the tour solver for the current indx.
REQ-005 SHALL have port indx, output, 5: index of the move being read (0..23).
REQ-006 SHALL have ports cmd_UART (input, 16), cmd_rdy_UART (input, 1) and clr_cmd_rdy_UART (output, 1): pass-through command channel from the UART.
REQ-007 SHALL have ports cmd (output, 16), cmd_rdy (output, 1) and clr_cmd_rdy (input, 1): command channel to the motion controller.
REQ-008 SHALL have port send_resp, input, 1: motion controller pulse meaning the current command has completed.
REQ-009 SHALL have port resp, output, 8: response byte to the UART.
REQ-010 SHALL have port err, output, 1: sticky illegal-move flag.

Function
REQ-011 Command format SHALL be {opcode[3:0], heading[7:0], squares[3:0]}.
- Opcode MOVE = 4'h4; MOVE_FANFARE = 4'h5.
- Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
REQ-012 Move decode SHALL use these (dx,dy) values, with +y = north and +x = east:
- bit0 (-1,+2), bit1 (+1,+2), bit2 (-2,+1), bit3 (-2,-1)
- bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
REQ-013 Each move SHALL produce two commands in order:
- Vertical: heading north/south by the sign of dy, squares = |dy|.
- Horizontal: heading east/west by the sign of dx, squares = |dx|.
REQ-014 The FSM SHALL have states IDLE, VERT, WAIT_V, HORZ, WAIT_H; the reset state is IDLE.
REQ-015 In IDLE:
- cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, and clr_cmd_rdy_UART = clr_cmd_rdy, all combinational.
- start_tour SHALL clear indx to 0 and go to VERT on the next edge.
REQ-016 Outside IDLE, clr_cmd_rdy_UART SHALL be 0 and the UART inputs SHALL be ignored.
REQ-017 In VERT, cmd_rdy SHALL be 1 with the vertical command; clr_cmd_rdy SHALL move the FSM to WAIT_V.
REQ-018 In WAIT_V, cmd_rdy SHALL be 0; send_resp SHALL move the FSM to HORZ.
REQ-019 In HORZ, cmd_rdy SHALL be 1 with the horizontal command; clr_cmd_rdy SHALL move the FSM to WAIT_H.
REQ-020 In WAIT_H, on send_resp: if indx == 23, go to IDLE; otherwise increment indx and go to VERT.
REQ-021 The opcode SHALL be MOVE for every command except the horizontal command at indx 23, which SHALL use MOVE_FANFARE.
REQ-022 resp SHALL be 8'hA5 in IDLE and 8'h5A in every other state.
REQ-023 The following SHALL be ignored:
- start_tour outside IDLE.
- clr_cmd_rdy in WAIT_V and WAIT_H.
- send_resp in VERT and HORZ.
REQ-024 cmd SHALL stay stable for the entire time cmd_rdy is 1.

Reset
REQ-025 On rst, on the next edge the block SHALL reach: state IDLE, indx 0, err 0.
- Mid-tour reset SHALL abandon the tour with no further tour commands.
- Outputs then follow the IDLE pass-through rule.

Configuration
REQ-026 With TOUR_CMD_CHK_EN defined, a move that is not exactly one-hot SHALL be handled when sampled in VERT:
- err is set to 1 and stays 1 until rst or the next accepted start_tour.
- The FSM goes to IDLE; no command is issued and cmd_rdy stays 0.
REQ-027 Without TOUR_CMD_CHK_EN:
- err SHALL be tied to 0.
- Decode SHALL use the lowest set bit of move.
- move == 0 SHALL produce a north, 0-square command on both legs.

Structure
REQ-028 The shared package tour_pkg SHALL hold the move one-hot constants, the opcode and heading constants, and the state enum.
REQ-029 A combinational sub-module tour_move_decode SHALL map move to the vertical and horizontal heading and squares.

Verification
REQ-030 Reset then IDLE: cmd_UART = 16'h4123 with cmd_rdy_UART = 1 SHALL give cmd = 16'h4123 and cmd_rdy = 1; clr_cmd_rdy = 1 SHALL give clr_cmd_rdy_UART = 1.
REQ-031 start_tour with move = 8'h01 at indx 0 SHALL give VERT cmd 16'h4002; after clr_cmd_rdy and send_resp, HORZ cmd SHALL be 16'h43F1.
REQ-032 move = 8'h40 SHALL give cmd 16'h47F1, then cmd 16'h4BF2.
REQ-033 A full 24-move playback SHALL give 48 commands and indx 0..23; the last command SHALL have opcode 4'h5, and resp SHALL return to 8'hA5.
REQ-034 rst asserted in WAIT_H at indx 10 SHALL give, after one edge: IDLE, indx 0, cmd_rdy following cmd_rdy_UART.
REQ-035 With TOUR_CMD_CHK_EN, move = 8'h03 at indx 5 SHALL give err = 1, return to IDLE, and no cmd_rdy pulse.
